// File: rtl/serial_link_pkg.sv
// Shared types for the serial link receive-clock delay trainer.
package serial_link_pkg;

  localparam int NumDelayCodes = 16;

  typedef logic [3:0] delay_code_t;
  typedef logic [4:0] win_len_t;

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, NEXT, EVAL, DONE} train_state_e;

  typedef struct packed {
    delay_code_t start;
    win_len_t    len;
  } window_t;

  // Lower-middle code of a non-empty window; start+len-1 <= 15, so no overflow.
  function automatic delay_code_t window_centre(input window_t w);
    win_len_t half;
    half = (w.len - 5'd1) >> 1;
    return w.start + half[3:0];
  endfunction

endpackage

// File: rtl/serial_link_window_find.sv
// Longest-run finder over a pass bitmap streamed in one bit per cycle, bit 0 first.
module serial_link_window_find
  import serial_link_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    start_i,
  input  logic    last_i,
  input  logic    bit_i,
  output window_t best_o,
  output logic    valid_o
);

  logic        scan_q, active;
  delay_code_t idx_q, idx;
  window_t     cur_q, best_q, cur_base, best_base, cur_d, best_d;

  assign active = start_i || scan_q;

  always_comb begin
    idx       = start_i ? '0 : idx_q;
    cur_base  = start_i ? '0 : cur_q;
    best_base = start_i ? '0 : best_q;
    cur_d     = '0;
    if (bit_i) begin
      cur_d.start = (cur_base.len == '0) ? idx : cur_base.start;
      cur_d.len   = cur_base.len + 5'd1;
    end
    best_d = best_base;
    // Strictly longer only, so the lowest-start window keeps ties.
    if (cur_d.len > best_base.len) best_d = cur_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scan_q  <= 1'b0;
      idx_q   <= '0;
      cur_q   <= '0;
      best_q  <= '0;
      valid_o <= 1'b0;
    end else if (active) begin
      scan_q  <= !last_i;
      idx_q   <= idx + 4'd1;
      cur_q   <= cur_d;
      best_q  <= best_d;
      valid_o <= last_i;
    end
  end

  assign best_o = best_q;

endmodule

// File: rtl/serial_link_delay_train.sv
// Receive-clock delay trainer: sweeps codes 0..15, checks the training pattern,
// and centres the delay line on the longest passing window.
module serial_link_delay_train
  import serial_link_pkg::*;
#(
  parameter int unsigned          DataWidth    = 8,
  parameter logic [DataWidth-1:0] Pattern      = 8'hA5,
  parameter int unsigned          SettleCycles = 8,
  parameter int unsigned          NumSamples   = 16,
  parameter delay_code_t          DefaultDelay = 4'd8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [DataWidth-1:0]     data_i,
  input  logic                     valid_i,
  output delay_code_t              delay_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     fail_o,
  output logic [NumDelayCodes-1:0] pass_map_o
);

  localparam int unsigned        SettleW    = $clog2(SettleCycles + 1);
  localparam int unsigned        BeatW      = $clog2(NumSamples + 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleCycles - 1);
  localparam logic [BeatW-1:0]   BeatLast   = BeatW'(NumSamples - 1);
  localparam delay_code_t        LastCode   = delay_code_t'(NumDelayCodes - 1);
  localparam logic [4:0]         ScanLast   = 5'(NumDelayCodes - 1);
  localparam logic [4:0]         EvalLast   = 5'(NumDelayCodes);

  train_state_e              state_q, state_d;
  delay_code_t               code_q, delay_q;
  logic [SettleW-1:0]        settle_cnt_q;
  logic [BeatW-1:0]          beat_cnt_q;
  logic                      parity_q, fail_q;
  logic [4:0]                eval_cnt_q;
  logic [NumDelayCodes-1:0]  pass_map_q;

  logic [DataWidth-1:0] exp_word;
  logic                 beat_bad, code_pass;
  logic                 wf_start, wf_last, wf_bit, best_vld;
  window_t              best;

  // Even beats carry Pattern, odd beats its complement.
  assign exp_word  = parity_q ? ~Pattern : Pattern;
  assign beat_bad  = valid_i && (data_i != exp_word);
  assign code_pass = valid_i && (data_i == exp_word) && (beat_cnt_q == BeatLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE:   if (start_i) state_d = SETTLE;
      SETTLE: if (settle_cnt_q == SettleLast) state_d = CHECK;
      CHECK:  if (beat_bad || code_pass) state_d = NEXT;
      NEXT:   state_d = (code_q == LastCode) ? EVAL : SETTLE;
      EVAL:   if (eval_cnt_q == EvalLast) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_o = state_q inside {SETTLE, CHECK, NEXT, EVAL};
    done_o = (state_q == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      code_q       <= '0;
      delay_q      <= DefaultDelay;
      settle_cnt_q <= '0;
      beat_cnt_q   <= '0;
      parity_q     <= 1'b0;
      eval_cnt_q   <= '0;
      fail_q       <= 1'b0;
      pass_map_q   <= '0;
    end else begin
      settle_cnt_q <= (state_q == SETTLE) ? settle_cnt_q + SettleW'(1) : '0;
      eval_cnt_q   <= (state_q == EVAL) ? eval_cnt_q + 5'd1 : '0;
      if (state_q != CHECK) begin
        beat_cnt_q <= '0;
        parity_q   <= 1'b0;
      end else if (valid_i) begin
        beat_cnt_q <= beat_cnt_q + BeatW'(1);
        parity_q   <= ~parity_q;
      end
      case (state_q)
        IDLE: if (start_i) begin
          code_q     <= '0;
          delay_q    <= '0;
          pass_map_q <= '0;
          fail_q     <= 1'b0;
        end
        CHECK: if (code_pass) pass_map_q[code_q] <= 1'b1;
        NEXT: if (code_q != LastCode) begin
          code_q  <= code_q + 4'd1;
          delay_q <= code_q + 4'd1;
        end
        EVAL: if (eval_cnt_q == EvalLast) begin
          if (!best_vld || best.len == '0) begin
            fail_q  <= 1'b1;
            delay_q <= DefaultDelay;
          end else begin
            delay_q <= window_centre(best);
          end
        end
        default: ;
      endcase
    end
  end

  assign wf_start = (state_q == EVAL) && (eval_cnt_q == '0);
  assign wf_last  = (state_q == EVAL) && (eval_cnt_q == ScanLast);
  assign wf_bit   = pass_map_q[eval_cnt_q[3:0]];

  serial_link_window_find u_window_find (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (wf_start),
    .last_i  (wf_last),
    .bit_i   (wf_bit),
    .best_o  (best),
    .valid_o (best_vld)
  );

  assign delay_o    = delay_q;
  assign fail_o     = fail_q;
  assign pass_map_o = pass_map_q;

endmodule

// File: tb/tb_serial_link_delay_train.sv
// Bench for serial_link_delay_train: a channel model drives the training pattern
// per delay code, results are compared against a brute-force window search.
module tb_serial_link_delay_train;

  localparam int         SETTLE = 8;
  localparam int         NS     = 16;
  localparam logic [7:0] PAT    = 8'hA5;
  localparam logic [3:0] DEF    = 4'd8;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, valid_i;
  logic [7:0]  data_i;
  logic [3:0]  delay_o;
  logic        busy_o, done_o, fail_o;
  logic [15:0] pass_map_o;

  always #5 clk_i = ~clk_i;

  serial_link_delay_train dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .delay_o    (delay_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .fail_o     (fail_o),
    .pass_map_o (pass_map_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Channel model: which codes see a clean eye, and how the bad ones look.
  logic [15:0] good_mask;
  int          vmode;        // 0 always valid, 1 one beat in three, 2 random
  logic        const_bad;
  logic [7:0]  bad_word;
  int          fail_beat[16];
  logic [3:0]  last_delay = 4'd0;
  logic        last_busy  = 1'b0;
  int          cnt = 0, nbeat = 0, cyc = 0, run_edge = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [15:0] m, input int vm, input logic cb, input logic [7:0] bw);
    good_mask = m;
    vmode     = vm;
    const_bad = cb;
    bad_word  = bw;
    for (int k = 0; k < 16; k++) fail_beat[k] = 0;
  endtask

  // Advance one clock; after the edge, update the channel and drive next beat.
  task automatic tick();
    logic [7:0] expw;
    @(posedge clk_i);
    #1;
    cyc++;
    run_edge++;
    if (delay_o !== last_delay || (busy_o && !last_busy)) begin
      cnt   = 0;
      nbeat = 0;
    end else begin
      cnt++;
    end
    last_delay = delay_o;
    last_busy  = busy_o;
    case (vmode)
      0:       valid_i = 1'b1;
      1:       valid_i = ((cyc % 3) == 0);
      default: valid_i = 1'($urandom_range(0, 1));
    endcase
    if (cnt < SETTLE) begin
      data_i = const_bad ? bad_word : 8'($urandom);
    end else begin
      expw = ((nbeat % 2) == 1) ? ~PAT : PAT;
      if (good_mask[delay_o] || nbeat < fail_beat[delay_o]) data_i = expw;
      else if (const_bad) data_i = bad_word;
      else data_i = expw ^ (8'd1 << $urandom_range(0, 7));
      if (valid_i) nbeat++;
    end
  endtask

  // Longest all-ones run, lowest start on ties, no wrap; returns {fail, delay}.
  function automatic logic [4:0] ref_result(input logic [15:0] m);
    int bs, bl;
    bit all;
    bs = 0;
    bl = 0;
    for (int s = 0; s < 16; s++) begin
      for (int e = s; e < 16; e++) begin
        all = 1;
        for (int k = s; k <= e; k++) if (!m[k]) all = 0;
        if (all && (e - s + 1) > bl) begin
          bl = e - s + 1;
          bs = s;
        end
      end
    end
    if (bl == 0) return {1'b1, DEF};
    return {1'b0, 4'(bs + (bl - 1) / 2)};
  endfunction

  task automatic start_run(input string tag);
    start_i = 1'b1;
    run_edge = 0;
    tick();
    start_i = 1'b0;
    check({tag, "_busy_start"}, busy_o, 1);
    check({tag, "_delay_start"}, delay_o, 0);
    check({tag, "_map_cleared"}, pass_map_o, 0);
  endtask

  task automatic wait_done(input string tag, output int done_edge);
    done_edge = -1;
    for (int i = 0; i < 6000 && !done_o; i++) tick();
    check({tag, "_done_seen"}, done_o, 1);
    if (done_o) done_edge = run_edge;
  endtask

  task automatic finish_checks(input string tag, input logic [15:0] m, input logic [3:0] d,
                               input logic f);
    check({tag, "_map"}, pass_map_o, m);
    check({tag, "_delay"}, delay_o, d);
    check({tag, "_fail"}, fail_o, f);
    check({tag, "_busy_done"}, busy_o, 0);
    tick();
    check({tag, "_done_pulse"}, done_o, 0);
  endtask

  task automatic directed(input string tag, input logic [15:0] m, input logic [3:0] d);
    int de;
    cfg(m, 0, 1'b0, 8'h00);
    start_run(tag);
    wait_done(tag, de);
    finish_checks(tag, m, d, 1'b0);
  endtask

  initial begin
    int         de, extra;
    logic [15:0] m;
    logic [4:0]  r;

    rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; data_i = '0;
    cfg(16'hFFFF, 0, 1'b0, 8'h00);
    repeat (3) tick();
    check("rst_delay", delay_o, DEF);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_fail", fail_o, 0);
    check("rst_map", pass_map_o, 0);
    rst_i = 1'b0;
    tick();
    check("idle_delay_hold", delay_o, DEF);

    // All codes pass: latency reference point is the edge before start is driven.
    cfg(16'hFFFF, 0, 1'b0, 8'h00);
    start_run("all_pass");
    wait_done("all_pass", de);
    check("all_pass_done_edge", de, 418);
    finish_checks("all_pass", 16'hFFFF, 4'd7, 1'b0);

    // Eye open only on codes 5..10, closed codes see 8'h00.
    cfg(16'h07E0, 0, 1'b1, 8'h00);
    start_run("eye_5_10");
    wait_done("eye_5_10", de);
    finish_checks("eye_5_10", 16'h07E0, 4'd7, 1'b0);

    directed("tie_1_3_9_11", 16'h0E0E, 4'd2);
    directed("win_9_12", 16'h1E0E, 4'd10);
    directed("no_wrap", 16'hC003, 4'd0);
    directed("top_code_only", 16'h8000, 4'd15);

    // Never matching, then start in DONE is ignored and the next IDLE start taken.
    cfg(16'h0000, 0, 1'b1, 8'hFF);
    start_run("never");
    wait_done("never", de);
    check("never_map", pass_map_o, 0);
    check("never_fail", fail_o, 1);
    check("never_delay", delay_o, DEF);
    start_i = 1'b1;
    tick();
    check("never_done_pulse", done_o, 0);
    check("start_in_done_ignored", busy_o, 0);
    cfg(16'hFFFF, 1, 1'b0, 8'h00);
    tick();
    start_i = 1'b0;
    check("start_after_done", busy_o, 1);
    check("restart_fail_cleared", fail_o, 0);
    check("restart_delay", delay_o, 0);

    // Sparse valid beats, with a start pulse while busy.
    for (int i = 0; i < 2000 && delay_o != 4'd5; i++) tick();
    check("sparse_reach_code5", delay_o, 5);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_start_ignored", delay_o, 5);
    check("busy_start_still_busy", busy_o, 1);
    wait_done("sparse", de);
    finish_checks("sparse", 16'hFFFF, 4'd7, 1'b0);
    extra = 0;
    repeat (30) begin
      tick();
      if (done_o) extra++;
    end
    check("sparse_single_done", extra, 0);

    // Reset in the middle of CHECK on code 6.
    cfg(16'hFFFF, 0, 1'b0, 8'h00);
    start_run("rst_mid");
    for (int i = 0; i < 1000 && !(delay_o == 4'd6 && cnt == SETTLE + 3); i++) tick();
    check("rst_mid_reach", delay_o, 6);
    rst_i = 1'b1;
    tick();
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_delay", delay_o, DEF);
    check("rst_mid_map", pass_map_o, 0);
    check("rst_mid_done", done_o, 0);
    rst_i = 1'b0;
    tick();
    check("rst_mid_idle", busy_o, 0);
    start_run("after_rst");
    wait_done("after_rst", de);
    check("after_rst_done_edge", de, 418);
    finish_checks("after_rst", 16'hFFFF, 4'd7, 1'b0);

    // Random eyes with random valid gaps and random failing beat positions.
    for (int it = 0; it < 5; it++) begin
      m = 16'($urandom);
      if (it == 3) m = m | 16'h8001;
      cfg(m, 2, 1'b0, 8'h00);
      for (int k = 0; k < 16; k++)
        fail_beat[k] = (it == 0) ? NS - 1 : int'($urandom_range(0, NS - 1));
      r = ref_result(m);
      start_run("rand");
      wait_done("rand", de);
      finish_checks("rand", m, r[3:0], r[4]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
